// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//
// Single-issue reservation station between rename and execute. Renamed
// instructions are buffered until both physical source operands are ready.
// Readiness is tracked by snooping two wakeup broadcast ports. One ready
// instruction is offered per cycle over a valid/ready handshake.
//
// Build option:
//   RS_AGE_SELECT_EN  defined   -> an ENTRIES x ENTRIES age matrix is kept and
//                                  the oldest ready entry is selected.
//                     undefined -> the lowest-index ready entry is selected.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   disp_*            dispatch from rename (valid/ready, opcode, tags,
//                     source-ready bits from the scoreboard, instruction word)
//   wk0_*, wk1_*      wakeup broadcasts (valid + produced physical tag)
//   flush             synchronous squash of every entry
//   iss_*             issue to execute (valid/ready + payload; payload is zero
//                     whenever iss_valid is low)
//   count             number of occupied entries
// ---------------------------------------------------------------------------
module reservation_station #(
    parameter int ENTRIES = 8,
    parameter int PREG_W  = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    // dispatch
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  logic [6:0]                       disp_opcode,
    input  logic [PREG_W-1:0]                disp_ps1,
    input  logic [PREG_W-1:0]                disp_ps2,
    input  logic [PREG_W-1:0]                disp_pd,
    input  logic                             disp_rdy1,
    input  logic                             disp_rdy2,
    input  logic [31:0]                      disp_instr,
    // wakeup
    input  logic                             wk0_valid,
    input  logic [PREG_W-1:0]                wk0_tag,
    input  logic                             wk1_valid,
    input  logic [PREG_W-1:0]                wk1_tag,
    // squash
    input  logic                             flush,
    // issue
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [6:0]                       iss_opcode,
    output logic [PREG_W-1:0]                iss_ps1,
    output logic [PREG_W-1:0]                iss_ps2,
    output logic [PREG_W-1:0]                iss_pd,
    output logic [31:0]                      iss_instr,
    // occupancy
    output logic [$clog2(ENTRIES+1)-1:0]     count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES+1);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_rdy1;
    logic [ENTRIES-1:0] ent_rdy2;
    logic [6:0]         ent_opcode [ENTRIES];
    logic [PREG_W-1:0]  ent_ps1    [ENTRIES];
    logic [PREG_W-1:0]  ent_ps2    [ENTRIES];
    logic [PREG_W-1:0]  ent_pd     [ENTRIES];
    logic [31:0]        ent_instr  [ENTRIES];

    logic               lock_valid;
    logic [IDX_W-1:0]   lock_idx;
    logic [CNT_W-1:0]   count_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] wk_hit1;
    logic [ENTRIES-1:0] wk_hit2;
    logic [ENTRIES-1:0] ready_vec;
    logic               disp_hit1;
    logic               disp_hit2;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               dispatch_fire;
    logic               issue_fire;

    // Full blocks dispatch even when an issue retires an entry this cycle.
    assign disp_ready    = (count_q < CNT_W'(ENTRIES));
    assign dispatch_fire = disp_valid && disp_ready && !flush;

    // Same-cycle wakeup for the instruction being dispatched.
    assign disp_hit1 = (wk0_valid && (wk0_tag == disp_ps1)) ||
                       (wk1_valid && (wk1_tag == disp_ps1));
    assign disp_hit2 = (wk0_valid && (wk0_tag == disp_ps2)) ||
                       (wk1_valid && (wk1_tag == disp_ps2));

    always_comb begin
        wk_hit1 = '0;
        wk_hit2 = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            wk_hit1[i] = (wk0_valid && (wk0_tag == ent_ps1[i])) ||
                         (wk1_valid && (wk1_tag == ent_ps1[i]));
            wk_hit2[i] = (wk0_valid && (wk0_tag == ent_ps2[i])) ||
                         (wk1_valid && (wk1_tag == ent_ps2[i]));
        end
    end

    // Lowest-index free slot; only used when disp_ready guarantees one exists.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (!ent_valid[i]) free_idx = IDX_W'(i);
        end
    end

    // Ready bits are registered, so there is no wakeup -> iss_valid path.
    assign ready_vec = ent_valid & ent_rdy1 & ent_rdy2;

`ifdef RS_AGE_SELECT_EN
    // age_q[i][j] = 1 means entry i was dispatched before entry j.
    logic [ENTRIES-1:0][ENTRIES-1:0] age_q;
    logic [ENTRIES-1:0][ENTRIES-1:0] age_d;
    logic [ENTRIES-1:0]              older_ready;

    always_comb begin
        older_ready = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                if (ready_vec[j] && age_q[j][i]) older_ready[i] = 1'b1;
            end
        end
    end

    // Oldest ready entry: ready, and no ready entry is older than it.
    always_comb begin
        pick_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (ready_vec[i] && !older_ready[i]) pick_idx = IDX_W'(i);
        end
    end

    // A freed entry forgets its ordering; a new entry is younger than every
    // entry that stays valid across this edge.
    always_comb begin
        age_d = age_q;
        if (issue_fire) begin
            age_d[sel_idx] = '0;
            for (int j = 0; j < ENTRIES; j++) age_d[j][sel_idx] = 1'b0;
        end
        if (dispatch_fire) begin
            age_d[free_idx] = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                age_d[j][free_idx] = ent_valid[j] &&
                                     !(issue_fire && (sel_idx == IDX_W'(j)));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else if (flush) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Lowest-index ready entry.
    always_comb begin
        pick_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (ready_vec[i]) pick_idx = IDX_W'(i);
        end
    end
`endif

    // A locked candidate cannot be displaced by newly ready entries.
    assign sel_idx    = lock_valid ? lock_idx : pick_idx;
    assign iss_valid  = lock_valid || (|ready_vec);
    assign issue_fire = iss_valid && iss_ready && !flush;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every process
    // sees pre-edge values; later assignments in the block override earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid  <= '0;
            ent_rdy1   <= '0;
            ent_rdy2   <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            count_q    <= '0;
        end else if (flush) begin
            ent_valid  <= '0;
            ent_rdy1   <= '0;
            ent_rdy2   <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            count_q    <= '0;
        end else begin
            // Wakeup snoop; ready bits only ever set while valid.
            for (int i = 0; i < ENTRIES; i++) begin
                if (ent_valid[i]) begin
                    ent_rdy1[i] <= ent_rdy1[i] | wk_hit1[i];
                    ent_rdy2[i] <= ent_rdy2[i] | wk_hit2[i];
                end
            end

            if (issue_fire) begin
                ent_valid[sel_idx] <= 1'b0;
                ent_rdy1[sel_idx]  <= 1'b0;
                ent_rdy2[sel_idx]  <= 1'b0;
            end

            // free_idx is never the issuing entry (that one is still valid).
            if (dispatch_fire) begin
                ent_valid[free_idx] <= 1'b1;
                ent_rdy1[free_idx]  <= disp_rdy1 | disp_hit1;
                ent_rdy2[free_idx]  <= disp_rdy2 | disp_hit2;
            end

            if (issue_fire) begin
                lock_valid <= 1'b0;
            end else if (iss_valid && !iss_ready) begin
                lock_valid <= 1'b1;
                lock_idx   <= sel_idx;
            end

            case ({dispatch_fire, issue_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload storage
    // ------------------------------------------------------------------
    // NOTE: payload arrays carry no reset; every read is qualified by the
    // entry's valid bit, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (dispatch_fire) begin
            ent_opcode[free_idx] <= disp_opcode;
            ent_ps1[free_idx]    <= disp_ps1;
            ent_ps2[free_idx]    <= disp_ps2;
            ent_pd[free_idx]     <= disp_pd;
            ent_instr[free_idx]  <= disp_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign iss_opcode = iss_valid ? ent_opcode[sel_idx] : '0;
    assign iss_ps1    = iss_valid ? ent_ps1[sel_idx]    : '0;
    assign iss_ps2    = iss_valid ? ent_ps2[sel_idx]    : '0;
    assign iss_pd     = iss_valid ? ent_pd[sel_idx]     : '0;
    assign iss_instr  = iss_valid ? ent_instr[sel_idx]  : '0;
    assign count      = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//
// Directed bench for reservation_station (ENTRIES=8, PREG_W=6). Inputs change
// 1 ns after a rising edge; outputs are sampled in the same window, well away
// from the next edge. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_reservation_station;

    localparam int ENTRIES = 8;
    localparam int PREG_W  = 6;

    logic              clk;
    logic              rst;
    logic              disp_valid;
    logic              disp_ready;
    logic [6:0]        disp_opcode;
    logic [PREG_W-1:0] disp_ps1;
    logic [PREG_W-1:0] disp_ps2;
    logic [PREG_W-1:0] disp_pd;
    logic              disp_rdy1;
    logic              disp_rdy2;
    logic [31:0]       disp_instr;
    logic              wk0_valid;
    logic [PREG_W-1:0] wk0_tag;
    logic              wk1_valid;
    logic [PREG_W-1:0] wk1_tag;
    logic              flush;
    logic              iss_valid;
    logic              iss_ready;
    logic [6:0]        iss_opcode;
    logic [PREG_W-1:0] iss_ps1;
    logic [PREG_W-1:0] iss_ps2;
    logic [PREG_W-1:0] iss_pd;
    logic [31:0]       iss_instr;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;

    reservation_station #(.ENTRIES(ENTRIES), .PREG_W(PREG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_opcode(disp_opcode),
        .disp_ps1   (disp_ps1),
        .disp_ps2   (disp_ps2),
        .disp_pd    (disp_pd),
        .disp_rdy1  (disp_rdy1),
        .disp_rdy2  (disp_rdy2),
        .disp_instr (disp_instr),
        .wk0_valid  (wk0_valid),
        .wk0_tag    (wk0_tag),
        .wk1_valid  (wk1_valid),
        .wk1_tag    (wk1_tag),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_opcode (iss_opcode),
        .iss_ps1    (iss_ps1),
        .iss_ps2    (iss_ps2),
        .iss_pd     (iss_pd),
        .iss_instr  (iss_instr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid  = 1'b0;
        disp_opcode = '0;
        disp_ps1    = '0;
        disp_ps2    = '0;
        disp_pd     = '0;
        disp_rdy1   = 1'b0;
        disp_rdy2   = 1'b0;
        disp_instr  = '0;
        wk0_valid   = 1'b0;
        wk0_tag     = '0;
        wk1_valid   = 1'b0;
        wk1_tag     = '0;
        flush       = 1'b0;
        iss_ready   = 1'b0;
    endtask

    // Present one instruction on the dispatch port (caller advances the clock).
    task automatic drive_disp(input logic [PREG_W-1:0] ps1, input logic r1,
                              input logic [PREG_W-1:0] ps2, input logic r2,
                              input logic [PREG_W-1:0] pd);
        disp_valid  = 1'b1;
        disp_opcode = 7'h33;
        disp_ps1    = ps1;
        disp_rdy1   = r1;
        disp_ps2    = ps2;
        disp_rdy2   = r2;
        disp_pd     = pd;
        disp_instr  = {8'hA5, 6'(ps1), 6'(ps2), 6'(pd), 6'h0};
    endtask

    task automatic dispatch(input logic [PREG_W-1:0] ps1, input logic r1,
                            input logic [PREG_W-1:0] ps2, input logic r2,
                            input logic [PREG_W-1:0] pd);
        drive_disp(ps1, r1, ps2, r2, pd);
        step();
        disp_valid = 1'b0;
    endtask

    task automatic accept();
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();

        // ---------------- reset state ----------------
        check("rst_iss_valid", 32'(iss_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_iss_pd", 32'(iss_pd), 32'd0);
        drive_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd9);
        step();
        check("rst_disp_ignored", 32'(count), 32'd0);
        check("rst_disp_no_issue", 32'(iss_valid), 32'd0);
        idle();
        rst = 1'b0;
        step();

        // ---------------- basic dispatch -> issue ----------------
        dispatch(6'd3, 1'b1, 6'd4, 1'b1, 6'd10);
        check("basic_iss_valid", 32'(iss_valid), 32'd1);
        check("basic_iss_pd", 32'(iss_pd), 32'd10);
        check("basic_iss_ps1", 32'(iss_ps1), 32'd3);
        check("basic_iss_ps2", 32'(iss_ps2), 32'd4);
        check("basic_iss_opcode", 32'(iss_opcode), 32'h33);
        check("basic_iss_instr", iss_instr, {8'hA5, 6'd3, 6'd4, 6'd10, 6'h0});
        check("basic_count1", 32'(count), 32'd1);
        accept();
        check("basic_count0", 32'(count), 32'd0);
        check("basic_empty", 32'(iss_valid), 32'd0);
        check("basic_empty_pd", 32'(iss_pd), 32'd0);

        // ---------------- wakeup latency ----------------
        dispatch(6'd5, 1'b0, 6'd6, 1'b1, 6'd11);
        check("wk_wait0", 32'(iss_valid), 32'd0);
        wk1_valid = 1'b1;
        wk1_tag   = 6'd5;
        check("wk_no_comb_path", 32'(iss_valid), 32'd0);
        step();
        wk1_valid = 1'b0;
        check("wk_issue_next", 32'(iss_valid), 32'd1);
        check("wk_issue_pd", 32'(iss_pd), 32'd11);
        accept();
        check("wk_count0", 32'(count), 32'd0);

        // Wakeup in the dispatch cycle itself must not be lost.
        drive_disp(6'd8, 1'b0, 6'd9, 1'b0, 6'd12);
        wk0_valid = 1'b1;
        wk0_tag   = 6'd8;
        wk1_valid = 1'b1;
        wk1_tag   = 6'd9;
        step();
        idle();
        check("same_cycle_wk_valid", 32'(iss_valid), 32'd1);
        check("same_cycle_wk_pd", 32'(iss_pd), 32'd12);
        accept();

        // ---------------- full ----------------
        for (int i = 0; i < ENTRIES; i++) begin
            dispatch(6'(20 + i), 1'b0, 6'd40, 1'b1, 6'(16 + i));
        end
        check("full_count", 32'(count), 32'd8);
        check("full_disp_ready", 32'(disp_ready), 32'd0);
        check("full_no_issue", 32'(iss_valid), 32'd0);
        dispatch(6'd30, 1'b1, 6'd31, 1'b1, 6'd50);
        check("full_9th_rejected", 32'(count), 32'd8);
        check("full_9th_no_issue", 32'(iss_valid), 32'd0);
        wk0_valid = 1'b1;
        wk0_tag   = 6'd23;
        step();
        wk0_valid = 1'b0;
        check("full_woken_pd", 32'(iss_pd), 32'd19);
        // Issue and a dispatch attempt together while full: dispatch blocked.
        drive_disp(6'd30, 1'b1, 6'd31, 1'b1, 6'd50);
        accept();
        disp_valid = 1'b0;
        check("full_after_accept_count", 32'(count), 32'd7);
        check("full_after_accept_ready", 32'(disp_ready), 32'd1);
        check("full_no_credit", 32'(iss_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("full_flush_count", 32'(count), 32'd0);

        // ---------------- age vs index select ----------------
        dispatch(6'd60, 1'b0, 6'd0, 1'b1, 6'd40);   // entry 0
        dispatch(6'd61, 1'b0, 6'd0, 1'b1, 6'd41);   // entry 1
        dispatch(6'd62, 1'b0, 6'd0, 1'b1, 6'd1);    // entry 2 : A
        wk0_valid = 1'b1;
        wk0_tag   = 6'd60;
        step();
        wk0_valid = 1'b0;
        check("age_free0_pd", 32'(iss_pd), 32'd40);
        accept();
        dispatch(6'd63, 1'b0, 6'd0, 1'b1, 6'd2);    // entry 0 : B
        wk0_valid = 1'b1;
        wk0_tag   = 6'd62;
        wk1_valid = 1'b1;
        wk1_tag   = 6'd63;
        step();
        idle();
`ifdef RS_AGE_SELECT_EN
        check("age_first_pd", 32'(iss_pd), 32'd1);
        accept();
        check("age_second_pd", 32'(iss_pd), 32'd2);
`else
        check("index_first_pd", 32'(iss_pd), 32'd2);
        accept();
        check("index_second_pd", 32'(iss_pd), 32'd1);
`endif
        accept();
        check("age_count_left", 32'(count), 32'd1);
        check("age_left_not_ready", 32'(iss_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // ---------------- lock ----------------
        dispatch(6'd50, 1'b0, 6'd0, 1'b1, 6'd30);   // entry 0, older, unready
        dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd7);     // entry 1, ready
        check("lock_initial_pd", 32'(iss_pd), 32'd7);
        wk0_valid = 1'b1;                           // older entry wakes now
        wk0_tag   = 6'd50;
        step();
        wk0_valid = 1'b0;
        check("lock_hold_pd_a", 32'(iss_pd), 32'd7);
        step();
        check("lock_hold_pd_b", 32'(iss_pd), 32'd7);
        check("lock_hold_valid", 32'(iss_valid), 32'd1);
        accept();
        check("lock_next_pd", 32'(iss_pd), 32'd30);
        accept();
        check("lock_count0", 32'(count), 32'd0);

        // ---------------- flush priority ----------------
        dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd21);
        dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd22);
        dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd23);
        check("flush_pre_count", 32'(count), 32'd3);
        drive_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd24);
        iss_ready = 1'b1;
        flush     = 1'b1;
        step();
        idle();
        check("flush_count", 32'(count), 32'd0);
        check("flush_iss_valid", 32'(iss_valid), 32'd0);
        check("flush_disp_ready", 32'(disp_ready), 32'd1);
        step();
        step();
        check("flush_nothing_later", 32'(iss_valid), 32'd0);
        check("flush_count_later", 32'(count), 32'd0);

        // ---------------- async reset mid-operation ----------------
        dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd25);
        dispatch(6'd3, 1'b0, 6'd2, 1'b1, 6'd26);
        check("arst_pre_valid", 32'(iss_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_iss_valid", 32'(iss_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_iss_pd", 32'(iss_pd), 32'd0);
        check("arst_disp_ready", 32'(disp_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        check("arst_post_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
